// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and helpers for the multiply/divide unit.
// Optional divider datapath is selected with the MULTDIV_DIV_EN macro.
package multdiv_pkg;

   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 6;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMult = 2'd1;
   localparam logic [1:0] StDiv  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // Magnitude of a two's-complement value; INT_MIN maps to 2^31 as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear and enable, flags the last iteration.
module multdiv_counter
   import multdiv_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);

   localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER_COUNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = en_i && (cnt_q == LastIter);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Fixed 33-cycle latency. Define MULTDIV_DIV_EN to build the divider; without
// it a divide request completes one cycle later with the exception flag set.
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             start;
   logic             iter_en;
   logic             iter_done;

   // Booth product register {hi, lo, qm1}, multiplicand held separately.
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             qm1_q, qm1_d;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH-1:0] booth_hi, booth_lo;
   logic             booth_qm1;
   logic             mult_ovf;

`ifdef MULTDIV_DIV_EN
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             neg_q, neg_d;
   logic             dexc_q, dexc_d;
   logic             div_ge;
   logic [WIDTH-1:0] div_shift, div_rem, div_quo, div_signed;
`endif

   assign start   = ctrl_MULT | ctrl_DIV;
   assign iter_en = (state_q == StMult) || (state_q == StDiv);

   multdiv_counter u_counter (
      .clk_i   (clock),
      .reset_i (ctrl_reset),
      .clr_i   (start),
      .en_i    (iter_en),
      .done_o  (iter_done)
   );

   // One Booth step: conditional add/sub of the multiplicand, then arithmetic shift.
   // The sum is one bit wider so subtracting INT_MIN cannot wrap.
   always_comb begin
      booth_sum = {hi_q[WIDTH-1], hi_q};
      case ({lo_q[0], qm1_q})
         2'b01:   booth_sum = {hi_q[WIDTH-1], hi_q} + {mcand_q[WIDTH-1], mcand_q};
         2'b10:   booth_sum = {hi_q[WIDTH-1], hi_q} - {mcand_q[WIDTH-1], mcand_q};
         default: booth_sum = {hi_q[WIDTH-1], hi_q};
      endcase
      booth_hi  = booth_sum[WIDTH:1];
      booth_lo  = {booth_sum[0], lo_q[WIDTH-1:1]};
      booth_qm1 = lo_q[0];
      // Upper 33 bits of the 64-bit product must all match for a 32-bit fit.
      mult_ovf  = (booth_hi != {WIDTH{booth_lo[WIDTH-1]}});
   end

`ifdef MULTDIV_DIV_EN
   // One restoring-division step on magnitudes. The remainder stays below the
   // divisor, so the shifted partial remainder and difference fit in WIDTH bits.
   always_comb begin
      div_shift  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      div_ge     = ({rem_q, quo_q[WIDTH-1]} >= {1'b0, dvs_q});
      div_rem    = div_ge ? (div_shift - dvs_q) : div_shift;
      div_quo    = {quo_q[WIDTH-2:0], div_ge};
      div_signed = neg_q ? -div_quo : div_quo;
   end
`endif

   // Sequencing: a start pulse always wins and restarts; MULT beats DIV.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      exc_d    = exc_q;
      mcand_d  = mcand_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      qm1_d    = qm1_q;
`ifdef MULTDIV_DIV_EN
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      neg_d    = neg_q;
      dexc_d   = dexc_q;
`endif
      if (ctrl_MULT) begin
         state_d = StMult;
         mcand_d = data_operandA;
         hi_d    = '0;
         lo_d    = data_operandB;
         qm1_d   = 1'b0;
      end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
         state_d = StDiv;
         dvs_d   = mag32(data_operandB);
         rem_d   = '0;
         quo_d   = mag32(data_operandA);
         neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         dexc_d  = (data_operandB == '0) ||
                   ((data_operandA == INT_MIN) && (data_operandB == '1));
`else
         state_d  = StDone;
         result_d = '0;
         exc_d    = 1'b1;
`endif
      end else begin
         case (state_q)
            StMult: begin
               hi_d  = booth_hi;
               lo_d  = booth_lo;
               qm1_d = booth_qm1;
               if (iter_done) begin
                  state_d  = StDone;
                  result_d = booth_lo;
                  exc_d    = mult_ovf;
               end
            end
`ifdef MULTDIV_DIV_EN
            StDiv: begin
               rem_d = div_rem;
               quo_d = div_quo;
               if (iter_done) begin
                  state_d  = StDone;
                  result_d = dexc_q ? '0 : div_signed;
                  exc_d    = dexc_q;
               end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         exc_q    <= 1'b0;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         qm1_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         neg_q    <= 1'b0;
         dexc_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         qm1_q    <= qm1_d;
`ifdef MULTDIV_DIV_EN
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         neg_q    <= neg_d;
         dexc_q   <= dexc_d;
`endif
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == StDone);
   assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit; expectations follow MULTDIV_DIV_EN.
module tb_multdiv_unit;

   logic        clock;
   logic        ctrl_reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

`ifdef MULTDIV_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif
   localparam int DivLat = DivEn ? 33 : 1;

   multdiv_unit #(
      .WIDTH (32)
   ) dut (
      .clock          (clock),
      .ctrl_reset     (ctrl_reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op at the current negedge and follow it to its ready pulse.
   task automatic run_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_res, input logic exp_exc);
      int          lat;
      logic [31:0] res;
      logic        exc;
      lat = 0;
      res = '0;
      exc = 1'b0;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      for (int n = 1; n <= 60 && lat == 0; n++) begin
         @(negedge clock);
         if (n == 1) begin
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = 1'b0;
            data_operandA = 32'hDEAD_BEEF;
            data_operandB = 32'h1234_5678;
         end
         if (data_resultRDY) begin
            lat = n;
            res = data_result;
            exc = data_exception;
         end
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_res"}, res, exp_res);
      check_eq({tag, "_exc"}, 32'(exc), 32'(exp_exc));
      @(negedge clock);
      check_eq({tag, "_rdy_low"}, 32'(data_resultRDY), 32'd0);
      check_eq({tag, "_hold"}, data_result, exp_res);
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   // MULT 5x5 aborted at cycle 10 by a second op; exactly one ready pulse expected.
   task automatic abort_op(input string tag, input logic m2, input logic [31:0] a2,
                           input logic [31:0] b2, input int exp_at,
                           input logic [31:0] exp_res, input logic exp_exc);
      int          pulses;
      int          first;
      logic [31:0] res;
      logic        exc;
      pulses = 0;
      first  = 0;
      res    = '0;
      exc    = 1'b0;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd5;
      data_operandB = 32'd5;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clock);
         if (data_resultRDY) begin
            pulses++;
            if (first == 0) begin
               first = n;
               res   = data_result;
               exc   = data_exception;
            end
         end
         ctrl_MULT = 1'b0;
         ctrl_DIV  = 1'b0;
         if (n == 10) begin
            ctrl_MULT     = m2;
            ctrl_DIV      = !m2;
            data_operandA = a2;
            data_operandB = b2;
         end
      end
      check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
      check_eq({tag, "_at"}, 32'(first), 32'(exp_at));
      check_eq({tag, "_res"}, res, exp_res);
      check_eq({tag, "_exc"}, 32'(exc), 32'(exp_exc));
   endtask

   initial begin
      int          pulses;
      int          first;
      int          second;
      logic [31:0] res1;
      logic [31:0] res2;

      ctrl_reset    = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(negedge clock);
      check_eq("rst_result", data_result, 32'h0);
      check_eq("rst_exc", 32'(data_exception), 32'd0);
      check_eq("rst_rdy", 32'(data_resultRDY), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      ctrl_reset = 1'b0;

      // Multiply
      run_op("mul_7xm3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 0);
      run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 33, 32'h0, 1);
      run_op("mul_minx1", 1, 0, 32'h8000_0000, 32'd1, 33, 32'h8000_0000, 0);
      run_op("mul_negneg", 1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 33, 32'd30, 0);
      run_op("mul_minxm1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1);
      run_op("mul_minxmin", 1, 0, 32'h8000_0000, 32'h8000_0000, 33, 32'h0, 1);
      run_op("mul_m1xm1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd1, 0);
      run_op("mul_wins", 1, 1, 32'd6, 32'd3, 33, 32'd18, 0);

      // Divide
      run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, DivLat,
             DivEn ? 32'hFFFF_FFFD : 32'h0, !DivEn);
      run_op("div_100_0", 0, 1, 32'd100, 32'd0, DivLat, 32'h0, 1);
      run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, DivLat, 32'h0, 1);
      run_op("div_100_7", 0, 1, 32'd100, 32'd7, DivLat, DivEn ? 32'd14 : 32'h0, !DivEn);
      run_op("div_m100_7", 0, 1, 32'hFFFF_FF9C, 32'd7, DivLat,
             DivEn ? 32'hFFFF_FFF2 : 32'h0, !DivEn);
      run_op("div_7_m100", 0, 1, 32'd7, 32'hFFFF_FF9C, DivLat, 32'h0, !DivEn);
      run_op("div_9_3", 0, 1, 32'd9, 32'd3, DivLat, DivEn ? 32'd3 : 32'h0, !DivEn);

      // Abort and restart
      abort_op("abort_div", 0, 32'd20, 32'd4, DivEn ? 43 : 11, DivEn ? 32'd5 : 32'h0, !DivEn);
      abort_op("abort_mul", 1, 32'd3, 32'd7, 43, 32'd21, 0);

      // Reset in the middle of a multiply
      pulses        = 0;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd9;
      data_operandB = 32'd9;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clock);
         if (data_resultRDY) pulses++;
         ctrl_MULT = 1'b0;
         if (n == 16) begin
            check_eq("midrst_result", data_result, 32'h0);
            check_eq("midrst_exc", 32'(data_exception), 32'd0);
            check_eq("midrst_rdy", 32'(data_resultRDY), 32'd0);
            check_eq("midrst_busy", 32'(busy), 32'd0);
            ctrl_reset = 1'b0;
         end
         if (n == 15) ctrl_reset = 1'b1;
      end
      check_eq("midrst_pulses", 32'(pulses), 32'd0);
      run_op("mul_3x4", 1, 0, 32'd3, 32'd4, 33, 32'd12, 0);

      // New start in the DONE cycle
      first         = 0;
      second        = 0;
      res1          = '0;
      res2          = '0;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd2;
      data_operandB = 32'd3;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clock);
         ctrl_MULT = 1'b0;
         if (data_resultRDY) begin
            if (first == 0) begin
               first         = n;
               res1          = data_result;
               ctrl_MULT     = 1'b1;
               data_operandA = 32'd4;
               data_operandB = 32'd5;
            end else if (second == 0) begin
               second = n;
               res2   = data_result;
            end
         end
      end
      check_eq("b2b_first_at", 32'(first), 32'd33);
      check_eq("b2b_first_res", res1, 32'd6);
      check_eq("b2b_second_at", 32'(second), 32'd66);
      check_eq("b2b_second_res", res2, 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multi-cycle signed 32-bit multiply/divide unit feeding the processor's 32-bit `register` write path. Takes two operands read from the register file, iterates one bit per cycle, and presents a 32-bit result plus exception flag for write-back into the destination register. Sits beside the ALU in execute; the pipeline stalls on it until `data_resultRDY` pulses.

## Interface
- `WIDTH`, 32: operand/result width; only 32 supported.
- `clock`  in  1  single clock; all state updates on rising edge.
- `ctrl_reset`  in  1  reset, synchronous and active-high.
- `ctrl_MULT`  in  1  one-cycle start pulse for multiply.
- `ctrl_DIV`  in  1  one-cycle start pulse for divide.
- `data_operandA`  in  32  signed multiplicand / dividend, sampled on start cycle only.
- `data_operandB`  in  32  signed multiplier / divisor, sampled on start cycle only.
- `data_result`  out  32  product low word or quotient.
- `data_exception`  out  1  overflow or divide-by-zero flag for current result.
- `data_resultRDY`  out  1  one-cycle pulse: result/exception valid.
- `busy`  out  1  high from cycle after start until the `data_resultRDY` cycle inclusive.

## Operation
- States: IDLE, MULT, DIV, DONE. 6-bit iteration counter.
- IDLE: start pulse latches operands, clears counter, enters MULT or DIV. Both pulses high together -> MULT wins.
- MULT: radix-2 Booth; 65-bit product register {upper 32, multiplier 32, q-1}; one add/sub + arithmetic shift per cycle; 32 iterations, then DONE.
- DIV: restoring division on magnitudes; 64-bit remainder/quotient register; one shift + trial subtract per cycle; 32 iterations, then DONE. Quotient negated if sign(A) xor sign(B); truncation toward zero.
- DONE: drives result, exception, `data_resultRDY`=1 for one cycle; returns to IDLE.
- Multiply exception: 64-bit product not representable in 32 signed bits (upper 33 bits not all equal); result = low 32 bits.
- Divide exception: B == 0, or A == 0x80000000 with B == 0xFFFFFFFF; result = 0.
- `data_result`/`data_exception` hold their DONE values until the next DONE or reset.
- Start pulse while busy: aborts in-flight op, relatches operands, restarts from iteration 0; no `data_resultRDY` for the aborted op.
- Reset outputs: `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0, state IDLE.

## Timing
- Start in cycle 0; iterations cycles 1-32; `data_resultRDY` high in cycle 33. Fixed 33-cycle latency for both operations, including exception cases (divide-by-zero still runs full count).
- `ctrl_reset` high in any cycle forces reset values on the next edge, overriding start pulses; mid-operation reset discards the op.
- Start asserted in the same cycle as DONE: DONE completes (ready pulse issued), new op begins next edge at iteration 0.

## Configuration
- `MULTDIV_DIV_EN` defined: full divider compiled in as above.
- Not defined: DIV state and divider datapath removed; `ctrl_DIV` pulse goes directly to DONE next cycle (ready at cycle 1) with `data_exception`=1, `data_result`=0. Multiply unchanged.

## Structure
- Package `multdiv_pkg`: state encoding, `ITER_COUNT`=32, `INT_MIN`=32'h80000000 constant.
- One sub-module `multdiv_counter`: 6-bit synchronous counter with sync clear and enable, `done` when count == 31 and enabled.
- Booth and divider datapaths stay in `multdiv_unit`.

## Test plan
- MULT 7 x -3 -> cycle 33: `data_resultRDY`=1, result 0xFFFFFFEB, exception 0.
- MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; 0x80000000 x 1 -> 0x80000000, exception 0.
- DIV -7 / 2 -> quotient 0xFFFFFFFD; DIV 100 / 0 -> result 0, exception 1; DIV 0x80000000 / -1 -> result 0, exception 1.
- Start MULT 5x5, at cycle 10 start DIV 20/4 -> single ready pulse 33 cycles after cycle 10, result 5, exception 0.
- Assert `ctrl_reset` at cycle 15 of a MULT -> next cycle all outputs 0, no ready pulse; subsequent MULT 3x4 -> 12 at latency 33.
- Without `MULTDIV_DIV_EN`: DIV 9/3 -> ready at cycle 1, result 0, exception 1.
